cache_control_4way: RTL
=======================

CACHE_CONTROL_4WAY -- requirements
Module: cache_control_4way

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning width of the miss and writeback performance counters.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-003 rst_n  input  1  the block SHALL use an asynchronous, active-low reset.
REQ-004 mem_read / mem_write  input  1 each  CPU request strobes, held until mem_resp.
REQ-005 mem_resp  output  1  one-cycle CPU completion pulse.
REQ-006 hit  input  4  per-way tag-match vector for the current set.
REQ-007 valid / dirty  input  4 each  per-way valid and dirty bits for the current set.
REQ-008 lru_out  input  2  pseudo-LRU victim way from the LRU array.
REQ-009 lru_read / lru_load  output  1 each  LRU array read enable and write enable.
REQ-010 lru_hit  output  4  one-hot accessed way, driven to the LRU array with lru_load.
REQ-011 way_sel  output  2  way steering for the data-out mux and the writeback source.
REQ-012 data_load  output  4  per-way data-array write enables.
REQ-013 tag_load / valid_set / dirty_set / dirty_clr  output  1 each  metadata updates for way way_sel.
REQ-014 pmem_read / pmem_write  output  1 each  physical-memory strobes, held until pmem_resp.
REQ-015 pmem_resp  input  1  physical-memory completion.
REQ-016 pmem_addr_sel  output  1  selects the physical-memory address: 0 = CPU address, 1 = victim tag address.
REQ-017 miss_count / wb_count  output  CNT_W each  performance counters.

Function
REQ-018 The block SHALL implement a state machine with states IDLE, COMPARE, WRITEBACK and ALLOCATE.
REQ-019 In IDLE with mem_read|mem_write, the block SHALL assert lru_read and go to COMPARE next cycle; with no request it SHALL stay in IDLE.
REQ-020 In COMPARE, the block SHALL assert lru_read in every cycle.
REQ-021 In COMPARE with |hit, the block SHALL, in the same cycle: pulse mem_resp; pulse lru_load; drive lru_hit with a one-hot of the hit way; drive way_sel with the encoded hit way; go to IDLE next cycle.
REQ-022 When the COMPARE hit is a write, the block SHALL also assert data_load[way] and dirty_set in that cycle.
REQ-023 When mem_read and mem_write are both high, the block SHALL treat the request as a write.
REQ-024 A multi-hot hit SHALL resolve to the lowest-index set bit, and lru_hit SHALL never be multi-hot.
REQ-025 In COMPARE with hit == 0 and a request present, the block SHALL latch the victim into a 2-bit register: the lowest-index way with valid == 0 if one exists, else lru_out.
REQ-026 On that miss, the block SHALL increment miss_count once, then go to WRITEBACK if valid[victim] & dirty[victim], else to ALLOCATE.
REQ-027 In COMPARE with no request, the block SHALL return to IDLE with no side effects.
REQ-028 In WRITEBACK, the block SHALL hold pmem_write = 1, pmem_addr_sel = 1 and way_sel = victim until pmem_resp.
REQ-029 On pmem_resp in WRITEBACK, the block SHALL pulse dirty_clr, increment wb_count and go to ALLOCATE.
REQ-030 In ALLOCATE, the block SHALL hold pmem_read = 1, pmem_addr_sel = 0 and way_sel = victim until pmem_resp.
REQ-031 On pmem_resp in ALLOCATE, the block SHALL pulse data_load[victim], tag_load and valid_set, then go to COMPARE, which re-evaluates and yields the hit.
REQ-032 pmem_resp outside WRITEBACK and ALLOCATE SHALL be ignored.
REQ-033 The block SHALL NOT drive mem_resp, lru_load or data_load in any state or cycle other than those in REQ-021, REQ-022 and REQ-031.
REQ-034 miss_count and wb_count SHALL saturate at all-ones and never wrap.
REQ-035 A request dropped mid-miss SHALL still complete the fill; COMPARE then returns to IDLE with no mem_resp.
REQ-036 All strobe outputs SHALL be decoded from the registered state (Moore-style) or from the state plus hit/pmem_resp, with no latches.

Reset
REQ-037 When rst_n is low, the block SHALL go to IDLE immediately and asynchronously.
REQ-038 During reset, the block SHALL clear the victim register, miss_count and wb_count, and drive all outputs to 0, including pmem strobes and lru_hit.
REQ-039 A reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL drop pmem_read/pmem_write in the same cycle, and the block SHALL not resume the operation afterward.

Verification
REQ-040 Read hit: mem_read, hit = 4'b0100 -> COMPARE cycle shows mem_resp = 1, lru_load = 1, lru_hit = 4'b0100, way_sel = 2; back in IDLE next cycle.
REQ-041 Clean miss: hit = 0, valid = 4'hF, dirty = 0, lru_out = 3, pmem_resp after 5 cycles -> pmem_read held 5 cycles; then data_load = 4'b1000 with tag_load and valid_set; hit on return to COMPARE; miss_count = 1; wb_count = 0.
REQ-042 Dirty miss: valid = 4'hF, dirty = 4'b0010, lru_out = 1 -> WRITEBACK with pmem_addr_sel = 1 and way_sel = 1, dirty_clr on pmem_resp, then ALLOCATE; wb_count = 1.
REQ-043 Invalid-way preference: valid = 4'b1011, lru_out = 0 -> victim = 2 (lowest invalid way), with no WRITEBACK.
REQ-044 Reset mid-ALLOCATE: rst_n low while pmem_read = 1 -> pmem_read = 0 within the same cycle; state is IDLE and both counters are 0 after release.
REQ-045 Saturation, with CNT_W = 2: 5 misses -> miss_count = 3.

Source files
------------

// File: rtl/cache_control_4way.sv
// Controller for a 4-way set-associative cache: tag compare, victim writeback and line fill.
// Victim choice prefers the lowest invalid way and falls back to the pseudo-LRU suggestion.
module cache_control_4way #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [3:0]       hit,
  input  logic [3:0]       valid,
  input  logic [3:0]       dirty,
  input  logic [1:0]       lru_out,
  output logic             lru_read,
  output logic             lru_load,
  output logic [3:0]       lru_hit,
  output logic [1:0]       way_sel,
  output logic [3:0]       data_load,
  output logic             tag_load,
  output logic             valid_set,
  output logic             dirty_set,
  output logic             dirty_clr,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic             pmem_addr_sel,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] victim, victim_nxt;
  logic [1:0] victim_pick;
  logic [1:0] hit_way;
  logic [3:0] hit_oh;
  logic       request;
  logic       miss_inc;
  logic       wb_inc;

  assign request   = mem_read | mem_write;
  assign state_dbg = state;

  // Lowest-index hit wins so lru_hit stays one-hot even on a corrupt multi-hit.
  always_comb begin
    hit_way = 2'd0;
    hit_oh  = 4'b0000;
    if (hit[0]) begin
      hit_way = 2'd0; hit_oh = 4'b0001;
    end else if (hit[1]) begin
      hit_way = 2'd1; hit_oh = 4'b0010;
    end else if (hit[2]) begin
      hit_way = 2'd2; hit_oh = 4'b0100;
    end else if (hit[3]) begin
      hit_way = 2'd3; hit_oh = 4'b1000;
    end
  end

  always_comb begin
    victim_pick = lru_out;
    if (!valid[0])      victim_pick = 2'd0;
    else if (!valid[1]) victim_pick = 2'd1;
    else if (!valid[2]) victim_pick = 2'd2;
    else if (!valid[3]) victim_pick = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      victim     <= 2'd0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state  <= state_nxt;
      victim <= victim_nxt;
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
      if (wb_inc && (wb_count != '1))     wb_count   <= wb_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    victim_nxt    = victim;
    miss_inc      = 1'b0;
    wb_inc        = 1'b0;
    mem_resp      = 1'b0;
    lru_read      = 1'b0;
    lru_load      = 1'b0;
    lru_hit       = 4'b0000;
    way_sel       = 2'd0;
    data_load     = 4'b0000;
    tag_load      = 1'b0;
    valid_set     = 1'b0;
    dirty_set     = 1'b0;
    dirty_clr     = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = 1'b0;
    case (state)
      IDLE: begin
        // Gated with rst_n so nothing leaks out while the block is held in reset.
        lru_read = request & rst_n;
        if (request) state_nxt = COMPARE;
      end
      COMPARE: begin
        lru_read = 1'b1;
        if (!request) begin
          state_nxt = IDLE;
        end else if (|hit) begin
          mem_resp  = 1'b1;
          lru_load  = 1'b1;
          lru_hit   = hit_oh;
          way_sel   = hit_way;
          state_nxt = IDLE;
          if (mem_write) begin
            data_load = hit_oh;
            dirty_set = 1'b1;
          end
        end else begin
          victim_nxt = victim_pick;
          miss_inc   = 1'b1;
          state_nxt  = (valid[victim_pick] & dirty[victim_pick]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim;
        if (pmem_resp) begin
          dirty_clr = 1'b1;
          wb_inc    = 1'b1;
          state_nxt = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = victim;
        if (pmem_resp) begin
          data_load = 4'b0001 << victim;
          tag_load  = 1'b1;
          valid_set = 1'b1;
          state_nxt = COMPARE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
